// File: rtl/cv32e40p_data_ram.sv
// Single-port 32-bit data RAM for the CV32E40P load/store unit, with range check and error pulse.
// Optional power-on clear sweep enabled by defining CV32E40P_DATA_RAM_CLEAR_EN.
module cv32e40p_data_ram #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        ready_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e state_q, state_d;

    logic [31:0] mem [DEPTH];

    // Range compare is done in 33 bits so a window ending at 4 GiB cannot wrap.
    logic [32:0]           addr_ext, base_ext, limit_ext;
    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  in_range;
    logic                  accept;
    logic                  reject;

    assign addr_ext  = {1'b0, data_addr_i};
    assign base_ext  = {1'b0, BASE_ADDR};
    assign limit_ext = base_ext + (33'(DEPTH) << 2);
    assign in_range  = (addr_ext >= base_ext) && (addr_ext < limit_ext);
    assign offset    = data_addr_i - BASE_ADDR;
    assign word_idx  = offset[ADDR_WIDTH+1:2];

    assign ready_o = (state_q == RUN);
    assign accept  = data_req_i && ready_o && in_range;
    assign reject  = data_req_i && !accept;

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic                  clr_last;

`ifdef CV32E40P_DATA_RAM_CLEAR_EN
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;

    assign clr_we   = (state_q == INIT);
    assign clr_idx  = clr_ptr_q;
    assign clr_last = (clr_ptr_q == {ADDR_WIDTH{1'b1}});

    always_comb begin
        clr_ptr_d = clr_ptr_q;
        if (clr_we) clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) clr_ptr_q <= '0;
        else        clr_ptr_q <= clr_ptr_d;
    end
`else
    assign clr_we   = 1'b0;
    assign clr_idx  = '0;
    assign clr_last = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && clr_last) state_d = RUN;
    end

    // Single write port shared between the clear sweep and accepted stores.
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [31:0]           wr_data;
    logic [3:0]            wr_be;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = word_idx;
        wr_data = data_wdata_i;
        wr_be   = data_be_i;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_idx  = clr_idx;
            wr_data = 32'h0;
            wr_be   = 4'hF;
        end else if (accept && data_we_i) begin
            wr_en   = 1'b1;
        end
    end

    // NOTE: storage has no reset branch so it maps onto RAM macros; rst_n only gates writes.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= INIT;
            data_rdata_o <= 32'h0;
            data_err_o   <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_err_o <= reject;
            if (accept && !data_we_i)      data_rdata_o <= mem[word_idx];
            else if (reject && !data_we_i) data_rdata_o <= 32'h0;
        end
    end

endmodule

// File: tb/tb_cv32e40p_data_ram.sv
// Directed self-checking bench for cv32e40p_data_ram (ADDR_WIDTH=4); honours CV32E40P_DATA_RAM_CLEAR_EN.
module tb_cv32e40p_data_ram;

    localparam int unsigned AW = 4;
`ifdef CV32E40P_DATA_RAM_CLEAR_EN
    localparam int INIT_LEN = 16;
`else
    localparam int INIT_LEN = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        ready_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cv32e40p_data_ram #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (32'h0001_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_req_i  (data_req_i),
        .data_addr_i (data_addr_i),
        .data_we_i   (data_we_i),
        .data_be_i   (data_be_i),
        .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o),
        .data_err_o  (data_err_o),
        .ready_o     (ready_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        data_req_i   = req;
        data_we_i    = we;
        data_addr_i  = addr;
        data_be_i    = be;
        data_wdata_i = wdata;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Release reset and count cycles until ready_o rises (bounded).
    task automatic wait_ready(input string name);
        int n = 0;
        rst_n = 1'b1;
        while (!ready_o && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n !== INIT_LEN) begin
            bad++;
            $display("FAIL %s: ready after %0d cycles, expected %0d", name, n, INIT_LEN);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_FFFC, 4'hF, 32'h0);
        tick();
        tick();
        total++;
        if (ready_o !== 1'b0 || data_err_o !== 1'b0 || data_rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: ready=%b err=%b rdata=%h, expected 0 0 00000000",
                     ready_o, data_err_o, data_rdata_o);
        end
        idle();
        wait_ready("reset_release");
    endtask

    task automatic test_clear();
`ifndef CV32E40P_DATA_RAM_CLEAR_EN
        drive(1'b1, 1'b1, 32'h0001_003C, 4'hF, 32'h0);
        tick();
`endif
        drive(1'b1, 1'b0, 32'h0001_003C, 4'hF, 32'h0);
        tick();
        idle();
        total++;
        if (data_rdata_o !== 32'h0 || data_err_o !== 1'b0) begin
            bad++;
            $display("FAIL last_word_load: rdata=%h err=%b, expected 00000000 0", data_rdata_o, data_err_o);
        end
    endtask

    task automatic test_store_load();
        drive(1'b1, 1'b1, 32'h0001_0008, 4'hF, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 1'b0, 32'h0001_0008, 4'h0, 32'h0);
        tick();
        idle();
        total++;
        if (data_rdata_o !== 32'hDEAD_BEEF || data_err_o !== 1'b0) begin
            bad++;
            $display("FAIL store_then_load: rdata=%h err=%b, expected deadbeef 0", data_rdata_o, data_err_o);
        end
        tick();
        total++;
        if (data_rdata_o !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL hold_after_idle: rdata=%h, expected deadbeef", data_rdata_o);
        end
        drive(1'b1, 1'b1, 32'h0001_0009, 4'b0010, 32'h0000_5500);
        tick();
        total++;
        if (data_rdata_o !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL hold_after_store: rdata=%h, expected deadbeef", data_rdata_o);
        end
        drive(1'b1, 1'b0, 32'h0001_000A, 4'h0, 32'h0);
        tick();
        idle();
        total++;
        if (data_rdata_o !== 32'hDEAD_55EF) begin
            bad++;
            $display("FAIL byte_lane_store: rdata=%h, expected dead55ef", data_rdata_o);
        end
        drive(1'b1, 1'b1, 32'h0001_0008, 4'b0000, 32'hFFFF_FFFF);
        tick();
        drive(1'b1, 1'b0, 32'h0001_0008, 4'h0, 32'h0);
        tick();
        idle();
        total++;
        if (data_rdata_o !== 32'hDEAD_55EF) begin
            bad++;
            $display("FAIL be_zero_store: rdata=%h, expected dead55ef", data_rdata_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'hA5A5_A5A5;
        vals[1] = 32'h1234_5678;
        vals[2] = 32'h0F0F_00FF;
        vals[3] = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h0001_0000 + 32'(i * 4), 4'hF, vals[i]);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h0001_0000 + 32'(i * 4), 4'h0, 32'h0);
            tick();
            total++;
            if (data_rdata_o !== vals[i] || data_err_o !== 1'b0) begin
                bad++;
                $display("FAIL b2b_load_%0d: rdata=%h err=%b, expected %h 0", i, data_rdata_o, data_err_o, vals[i]);
            end
        end
        idle();
    endtask

    task automatic test_errors();
        drive(1'b1, 1'b0, 32'h0000_FFFC, 4'h0, 32'h0);
        tick();
        idle();
        total++;
        if (data_err_o !== 1'b1 || data_rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL below_range_load: err=%b rdata=%h, expected 1 00000000", data_err_o, data_rdata_o);
        end
        tick();
        total++;
        if (data_err_o !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse_width: err=%b, expected 0", data_err_o);
        end
        drive(1'b1, 1'b0, 32'h0001_0004, 4'h0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h0001_0040, 4'hF, 32'hFFFF_FFFF);
        tick();
        idle();
        total++;
        if (data_err_o !== 1'b1 || data_rdata_o !== 32'h1234_5678) begin
            bad++;
            $display("FAIL above_range_store: err=%b rdata=%h, expected 1 12345678", data_err_o, data_rdata_o);
        end
        drive(1'b1, 1'b0, 32'h0001_0000, 4'h0, 32'h0);
        tick();
        idle();
        total++;
        if (data_err_o !== 1'b0 || data_rdata_o !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL word0_unchanged: err=%b rdata=%h, expected 0 a5a5a5a5", data_err_o, data_rdata_o);
        end
        drive(1'b1, 1'b0, 32'h0001_0040, 4'h0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 4'hF, 32'h1);
        tick();
        idle();
        total++;
        if (data_err_o !== 1'b1 || data_rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL b2b_reject: err=%b rdata=%h, expected 1 00000000", data_err_o, data_rdata_o);
        end
        tick();
        total++;
        if (data_err_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_reject_end: err=%b, expected 0", data_err_o);
        end
    endtask

    task automatic test_restart();
`ifdef CV32E40P_DATA_RAM_CLEAR_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'h0001_0000, 4'h0, 32'h0);
        tick();
        idle();
        total++;
        if (data_err_o !== 1'b1 || ready_o !== 1'b0 || data_rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL init_request: err=%b ready=%b rdata=%h, expected 1 0 00000000",
                     data_err_o, ready_o, data_rdata_o);
        end
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (data_err_o !== 1'b0 || ready_o !== 1'b0) begin
            bad++;
            $display("FAIL init_midway: err=%b ready=%b, expected 0 0", data_err_o, ready_o);
        end
        rst_n = 1'b0;
        tick();
        wait_ready("reset_mid_init");
`else
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 32'h0001_0000, 4'hF, 32'hFFFF_FFFF);
        tick();
        idle();
        total++;
        if (data_err_o !== 1'b0 || ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_cycle_request: err=%b ready=%b, expected 0 0", data_err_o, ready_o);
        end
        wait_ready("reset_mid_run");
        drive(1'b1, 1'b0, 32'h0001_0000, 4'h0, 32'h0);
        tick();
        idle();
        total++;
        if (data_rdata_o !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL reset_store_dropped: rdata=%h, expected a5a5a5a5", data_rdata_o);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_clear();
        test_store_load();
        test_back_to_back();
        test_errors();
        test_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
